// File: rtl/imem_burst_responder.sv
// Burst-capable instruction/data memory responder.
// Serves 1/4/8/16-beat reads and writes from a word array.
module imem_burst_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter logic [31:0] BASE_ADDR = 32'h8002_0000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        enable_in,
  input  logic [31:0] addr_in,
  input  logic        rw_in,
  input  logic [1:0]  access_size_in,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        valid_out,
  output logic        busy_out
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic {
    IDLE,
    BURST
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [3:0]    rem_q, rem_d;
  logic          rw_q, rw_d;
  logic [31:0]   data_q, data_d;
  logic          valid_q, valid_d;
  logic          mem_we;

  logic [31:0]   mem_q [DEPTH_WORDS];

  logic [31:0]   offs;
  logic [AW-1:0] start_idx;
  logic [3:0]    len_m1;
  logic          unused_offs;

  // Offset bits above the array width are dropped: addresses alias.
  always_comb begin
    offs      = addr_in - BASE_ADDR;
    start_idx = offs[AW+1:2];
    case (access_size_in)
      2'b00:   len_m1 = 4'd0;
      2'b01:   len_m1 = 4'd3;
      2'b10:   len_m1 = 4'd7;
      default: len_m1 = 4'd15;
    endcase
  end

  assign unused_offs = ^{offs[31:AW+2], offs[1:0]};

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rem_d   = rem_q;
    rw_d    = rw_q;
    data_d  = data_q;
    valid_d = 1'b0;
    mem_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable_in) begin
          idx_d   = start_idx;
          rw_d    = rw_in;
          rem_d   = len_m1;
          mem_we  = rw_in;
          valid_d = !rw_in;
          if (!rw_in) data_d = mem_q[start_idx];
          if (len_m1 != 4'd0) state_d = BURST;
        end
      end
      default: begin
        idx_d   = idx_q + AW'(1);
        rem_d   = rem_q - 4'd1;
        mem_we  = rw_q;
        valid_d = !rw_q;
        if (!rw_q) data_d = mem_q[idx_d];
        if (rem_q == 4'd1) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      idx_q   <= '0;
      rem_q   <= '0;
      rw_q    <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rem_q   <= rem_d;
      rw_q    <= rw_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  // Array contents survive reset.
  always_ff @(posedge clk_in) begin
    if (mem_we) mem_q[idx_d] <= data_in;
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign busy_out  = (state_q == BURST);

endmodule

// File: tb/tb_imem_burst_responder.sv
// Bench for imem_burst_responder: vector table plus
// scoreboarded read data and hand-built corner sequences.
module tb_imem_burst_responder;

  localparam int DEPTH = 256;
  localparam logic [31:0] BASE = 32'h8002_0000;

  logic        clk_in;
  logic        rst_in;
  logic        enable_in;
  logic [31:0] addr_in;
  logic        rw_in;
  logic [1:0]  access_size_in;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        valid_out;
  logic        busy_out;

  imem_burst_responder #(
    .DEPTH_WORDS(DEPTH),
    .BASE_ADDR(BASE)
  ) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .enable_in(enable_in),
    .addr_in(addr_in),
    .rw_in(rw_in),
    .access_size_in(access_size_in),
    .data_in(data_in),
    .data_out(data_out),
    .valid_out(valid_out),
    .busy_out(busy_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int tests = 0;
  int fails = 0;
  int vcount = 0;
  int vruns = 0;
  bit prev_valid = 1'b0;

  logic [31:0] mem_m [DEPTH];
  logic [31:0] exp_q [$];

  typedef struct {
    bit          rw;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] d0;
    int          exp_busy;
    int          exp_valid;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  function automatic int midx(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return int'((off >> 2) & 32'(DEPTH - 1));
  endfunction

  always @(negedge clk_in) begin
    if (valid_out) begin
      vcount++;
      if (!prev_valid) vruns++;
      if (exp_q.size() == 0) begin
        check("unexpected_valid", data_out, 32'hx);
      end else begin
        check("rdata", data_out, exp_q.pop_front());
      end
    end
    prev_valid = valid_out;
  end

  task automatic idle(input int n);
    enable_in = 1'b0;
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  // Leaves the bench 1 time unit after the last beat edge.
  task automatic run_op(input bit rw,
                        input logic [31:0] addr,
                        input logic [1:0] size,
                        input logic [31:0] d0,
                        input bit inject,
                        output int busy_cnt);
    int n;
    int b;
    n = (size == 2'd0) ? 1 :
        (size == 2'd1) ? 4 :
        (size == 2'd2) ? 8 : 16;
    b = midx(addr);
    busy_cnt = 0;
    enable_in = 1'b1;
    rw_in = rw;
    addr_in = addr;
    access_size_in = size;
    data_in = d0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk_in);
      if (rw) mem_m[(b + k) % DEPTH] = d0 + 32'(k);
      else exp_q.push_back(mem_m[(b + k) % DEPTH]);
      #1;
      if (busy_out) busy_cnt++;
      enable_in = 1'b0;
      data_in = d0 + 32'(k + 1);
      if (inject && k == 0) begin
        enable_in = 1'b1;
        rw_in = 1'b1;
        addr_in = BASE + 32'd400;
        data_in = 32'hBAD0_BAD0;
      end else if (inject && k == 1) begin
        rw_in = rw;
        addr_in = addr;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bc;
    int v0;
    int r0;

    vecs[0]  = '{1'b1, BASE,           2'd0, 32'hDEAD_BEEF, 0, 0};
    vecs[1]  = '{1'b0, BASE,           2'd0, 32'h0,         0, 1};
    vecs[2]  = '{1'b1, BASE + 32'h10,  2'd1, 32'd1,         3, 0};
    vecs[3]  = '{1'b0, BASE + 32'h10,  2'd1, 32'h0,         3, 4};
    vecs[4]  = '{1'b1, BASE + 32'h3F8, 2'd1, 32'hA,         3, 0};
    vecs[5]  = '{1'b0, BASE + 32'h3F8, 2'd0, 32'h0,         0, 1};
    vecs[6]  = '{1'b0, BASE + 32'h3FC, 2'd0, 32'h0,         0, 1};
    vecs[7]  = '{1'b0, BASE,           2'd0, 32'h0,         0, 1};
    vecs[8]  = '{1'b0, BASE + 32'h4,   2'd0, 32'h0,         0, 1};
    vecs[9]  = '{1'b1, BASE + 32'h190, 2'd0, 32'h1000_0064, 0, 0};
    vecs[10] = '{1'b1, BASE + 32'h20,  2'd3, 32'h5000_0000, 15, 0};
    vecs[11] = '{1'b0, BASE + 32'h3,   2'd0, 32'h0,         0, 1};
    vecs[12] = '{1'b0, BASE + 32'h20,  2'd2, 32'h0,         7, 8};

    rst_in = 1'b1;
    enable_in = 1'b0;
    rw_in = 1'b0;
    addr_in = '0;
    access_size_in = '0;
    data_in = '0;
    #12;
    check("rst_valid", 32'(valid_out), 32'd0);
    check("rst_busy", 32'(busy_out), 32'd0);
    check("rst_data", data_out, 32'd0);
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;

    for (int i = 0; i < 13; i++) begin
      v0 = vcount;
      run_op(vecs[i].rw, vecs[i].addr, vecs[i].size,
             vecs[i].d0, 1'b0, bc);
      idle(1);
      check($sformatf("busy_cycles[%0d]", i),
            32'(bc), 32'(vecs[i].exp_busy));
      check($sformatf("valid_cycles[%0d]", i),
            32'(vcount - v0), 32'(vecs[i].exp_valid));
    end

    // Ignored write during a burst, then back-to-back read.
    v0 = vcount;
    r0 = vruns;
    run_op(1'b0, BASE + 32'h10, 2'd1, 32'h0, 1'b1, bc);
    check("b2b_busy_final_beat", 32'(busy_out), 32'd0);
    run_op(1'b0, BASE + 32'h20, 2'd0, 32'h0, 1'b0, bc);
    idle(1);
    check("b2b_valid_cycles", 32'(vcount - v0), 32'd5);
    check("b2b_no_gap", 32'(vruns - r0), 32'd1);
    run_op(1'b0, BASE + 32'h190, 2'd0, 32'h0, 1'b0, bc);
    idle(1);

    // Reset while beat 5 of a 16-beat read is on the bus.
    enable_in = 1'b1;
    rw_in = 1'b0;
    addr_in = BASE + 32'h20;
    access_size_in = 2'd3;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk_in);
      exp_q.push_back(mem_m[8 + k]);
      #1;
      enable_in = 1'b0;
    end
    @(posedge clk_in);
    #2;
    check("pre_rst_busy", 32'(busy_out), 32'd1);
    rst_in = 1'b1;
    #1;
    check("mid_rst_valid", 32'(valid_out), 32'd0);
    check("mid_rst_busy", 32'(busy_out), 32'd0);
    check("mid_rst_data", data_out, 32'd0);
    @(posedge clk_in);
    @(posedge clk_in);
    #1;
    check("beats_before_rst", 32'(exp_q.size()), 32'd0);
    rst_in = 1'b0;
    run_op(1'b0, BASE, 2'd0, 32'h0, 1'b0, bc);
    idle(2);
    check("post_rst_word0", mem_m[0], 32'hC);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/imem_burst_responder.md
Name: imem_burst_responder

Overview:
- Memory-side responder to the fetch unit's request interface: pc/address, read/write select and access size.
- Services single-word and burst reads and writes out of an internal word array.
- Drives busy_out back to the requester's stall input while a burst is in progress.
- Sits between fetch (and later memory-stage) request ports and the behavioural main memory.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words in the array; must be a power of two.
- BASE_ADDR, 32'h80020000, byte address that maps to word 0.

Ports:
- clk_in  input  1  clock; all state updates on the rising edge.
- rst_in  input  1  reset, asynchronous, active-high.
- enable_in  input  1  request strobe; sampled on the rising edge.
- addr_in  input  32  byte address of the first beat; bits [1:0] ignored.
- rw_in  input  1  0 = read, 1 = write.
- access_size_in  input  2  burst length: 00 = 1 word, 01 = 4, 10 = 8, 11 = 16.
- data_in  input  32  write data for the current beat.
- data_out  output  32  read data for the current beat.
- valid_out  output  1  data_out holds a valid read beat this cycle.
- busy_out  output  1  responder cannot accept a new request this cycle; wired to the requester's stall_in.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high.
- Reset values: data_out = 0, valid_out = 0, busy_out = 0, state = IDLE, beat counter = 0.
- Reset does not clear array contents.
- Word index mapping: ((addr - BASE_ADDR) >> 2) mod DEPTH_WORDS, computed with a mask, no range error.
- Beat k of a burst uses index (start_index + k) mod DEPTH_WORDS, so bursts wrap at the top of the array.
- States: IDLE and BURST. busy_out = (state == BURST), decoded from registered state only.
- Acceptance: a request is accepted at edge E0 when state is IDLE and enable_in = 1.
- Acceptance latches start index, rw and length N; these inputs are ignored afterwards until the burst completes.
- Read, E0: data_out <= mem[start]; valid_out <= 1.
  - If N > 1: go to BURST with remaining = N-1.
  - Each following edge presents the next beat and decrements remaining.
  - The edge that presents the last beat returns to IDLE.
  - valid_out is high for exactly N consecutive cycles beginning the cycle after E0; beat 0 is visible one cycle after E0.
- Write, E0: mem[start] <= data_in; valid_out <= 0; data_out holds its previous value.
  - If N > 1: go to BURST with remaining = N-1. Each following edge writes data_in to the next index and decrements remaining.
  - The edge that writes the last beat returns to IDLE.
- busy_out timing:
  - High for N-1 cycles after a burst is accepted; 0 for N = 1.
  - Low in the cycle holding the final read beat, so a back-to-back request can be accepted on the very next edge with no bubble.
- enable_in while busy_out = 1 is ignored; no queuing.
- With state = IDLE and no request at an edge, valid_out <= 0.
- A read accepted immediately after a write to the same index returns the new data; the write completes before the read edge.
- Reset asserted mid-burst: outputs go to reset values immediately and the burst is abandoned.
  - Write beats already committed remain in the array.
  - The first edge after rst_in deasserts may accept a new request.
- Single-ported array; one access per cycle.

Test Plan:
- Single write/read: write 32'hDEADBEEF to 32'h80020000 (size 00), then read it back. Required: busy_out stays 0; valid_out is high for 1 cycle, one cycle after the read edge; data_out = DEADBEEF.
- 4-beat write/read: write 1, 2, 3, 4 at 32'h80020010 (size 01), then read the same. Required: busy_out is high 3 cycles for each burst; valid_out is high 4 consecutive cycles; data_out = 1, 2, 3, 4 in order.
- Wrap-around: 4-beat write of A, B, C, D at BASE + 32'h3F8 (word 254). Required: single reads show word 254 = A, 255 = B, 0 = C, 1 = D.
- Ignored request and back-to-back: during a 4-beat read, pulse enable_in with a write to word 100 while busy_out = 1. Required: word 100 is unchanged. A read issued in the final-beat cycle is accepted at the next edge; valid_out shows no gap between the two bursts.
- Reset mid-burst: 16-beat read (size 11); assert rst_in during beat 5. Required: valid_out, busy_out and data_out drop to 0 asynchronously. After release, a single read of word 0 returns the value written earlier (contents retained).
- Size/alignment: read with addr bits [1:0] = 2'b11 at BASE + 3. Required: returns word 0; an 8-beat read (size 10) gives exactly 8 valid_out cycles and 7 busy_out cycles.
